seq_det_ctrl: RTL and testbench

SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

---
 rtl/seq_det_ctrl.sv | 108 ++++++++++
 tb/tb_seq_det_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_ctrl.sv
// Serial pattern detector with run control: counts matches of a latched pattern
// and optionally stops once a target count is reached.
module seq_det_ctrl #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [PAT_W-1:0] i_pattern,
  input  logic             i_overlap,
  input  logic [CNT_W-1:0] i_target,
  input  logic             i_din,
  input  logic             i_din_valid,
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_match,
  output logic [CNT_W-1:0] o_match_cnt,
  output logic             o_done
);

  localparam int unsigned FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             r_state;
  logic [PAT_W-1:0]   r_pattern;
  logic               r_overlap;
  logic [CNT_W-1:0]   r_target;
  logic [PAT_W-1:0]   r_sreg;
  logic [FILL_W-1:0]  r_fill;
  logic               r_busy;
  logic               r_match;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_done;

  logic [PAT_W-1:0]   w_sreg;
  logic [FILL_W-1:0]  w_fill;
  logic               w_hit;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_reach;

  assign w_sreg    = {r_sreg[PAT_W-2:0], i_din};
  assign w_fill    = (r_fill == FILL_FULL) ? r_fill : r_fill + 1'b1;
  // Fill count guards against matching on stale or cleared window contents.
  assign w_hit     = (w_fill == FILL_FULL) && (w_sreg == r_pattern);
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
  assign w_reach   = (r_target != '0) && (w_cnt_inc == r_target);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_pattern <= '0;
      r_overlap <= 1'b0;
      r_target  <= '0;
      r_sreg    <= '0;
      r_fill    <= '0;
      r_busy    <= 1'b0;
      r_match   <= 1'b0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
    end else begin
      r_match <= 1'b0;
      r_done  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_pattern <= i_pattern;
            r_overlap <= i_overlap;
            r_target  <= i_target;
            r_sreg    <= '0;
            r_fill    <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_state   <= StRun;
          end
        end
        StRun: begin
          if (i_abort) begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end else if (i_din_valid) begin
            r_sreg <= w_sreg;
            r_fill <= (w_hit && !r_overlap) ? '0 : w_fill;
            if (w_hit) begin
              r_match <= 1'b1;
              r_cnt   <= w_cnt_inc;
              if (w_reach) begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= StDone;
              end
            end
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_match     = r_match;
  assign o_match_cnt = r_cnt;
  assign o_done      = r_done;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl: directed scenarios plus random traffic
// compared against a bit-history reference model.
module tb_seq_det_ctrl;

  localparam int unsigned PW = 4;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [PW-1:0] pattern = '0;
  logic          overlap = 1'b0;
  logic [CW-1:0] target = '0;
  logic          din = 1'b0;
  logic          din_valid = 1'b0;
  logic          abort = 1'b0;
  logic          busy, match, done;
  logic [CW-1:0] match_cnt;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model state
  bit        m_run, m_match, m_done, m_ovl;
  int        m_cnt, m_tgt;
  bit [3:0]  m_pat;
  bit        hist[$];

  seq_det_ctrl #(.PAT_W(PW), .CNT_W(CW)) u_dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_pattern   (pattern),
    .i_overlap   (overlap),
    .i_target    (target),
    .i_din       (din),
    .i_din_valid (din_valid),
    .i_abort     (abort),
    .o_busy      (busy),
    .o_match     (match),
    .o_match_cnt (match_cnt),
    .o_done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_run = 0; m_match = 0; m_done = 0; m_ovl = 0;
    m_cnt = 0; m_tgt = 0; m_pat = '0;
    hist.delete();
  endfunction

  // Evaluates the rules on the inputs present at the current rising edge.
  function automatic void model_step();
    bit [3:0] win;
    if (m_run) begin
      m_done = 0;
      if (abort) begin
        m_run = 0; m_match = 0;
      end else if (din_valid) begin
        hist.push_back(din);
        if (hist.size() > PW) void'(hist.pop_front());
        win = {hist[0], hist[1 % hist.size()], hist[2 % hist.size()], hist[hist.size()-1]};
        m_match = (hist.size() == PW) && (win == m_pat);
        if (m_match) begin
          if (m_cnt < (1 << CW) - 1) m_cnt++;
          if (!m_ovl) hist.delete();
          if (m_tgt != 0 && m_cnt == m_tgt) begin
            m_run = 0; m_done = 1;
          end
        end
      end else begin
        m_match = 0;
      end
    end else if (m_done) begin
      m_done = 0; m_match = 0;
    end else begin
      m_match = 0;
      if (start) begin
        m_pat = pattern; m_ovl = overlap; m_tgt = int'(target);
        m_cnt = 0; hist.delete(); m_run = 1;
      end
    end
  endfunction

  task automatic check_model(input string tag);
    chk({tag, ".busy"}, int'(busy), int'(m_run));
    chk({tag, ".match"}, int'(match), int'(m_match));
    chk({tag, ".done"}, int'(done), int'(m_done));
    chk({tag, ".cnt"}, int'(match_cnt), m_cnt);
  endtask

  task automatic step(input logic st, input logic [PW-1:0] pat, input logic ovl,
                      input logic [CW-1:0] tgt, input logic d, input logic dv,
                      input logic ab, input string tag);
    @(negedge clk);
    start = st; pattern = pat; overlap = ovl; target = tgt;
    din = d; din_valid = dv; abort = ab;
    @(posedge clk);
    model_step();
    #1;
    check_model(tag);
  endtask

  task automatic bit_in(input logic d, input logic dv, input string tag);
    step(1'b0, 4'b0000, 1'b0, 3'd0, d, dv, 1'b0, tag);
  endtask

  task automatic end_run();
    step(1'b0, 4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, "abort");
    step(1'b0, 4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, "idle");
  endtask

  bit [6:0] s7 = 7'b1011011;

  initial begin
    model_reset();
    #12;
    check_model("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 4'b0000, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, "idle_nostart");

    // Overlapping run, no target
    step(1'b1, 4'b1011, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, "ovl_start");
    for (int i = 6; i >= 0; i--) begin
      bit_in(s7[i], 1'b1, "ovl_bit");
      chk("ovl_match_exp", int'(match), int'(i == 3 || i == 0));
    end
    chk("ovl_cnt", int'(match_cnt), 2);
    chk("ovl_busy", int'(busy), 1);
    end_run();

    // Non-overlapping run
    step(1'b1, 4'b1011, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, "novl_start");
    for (int i = 6; i >= 0; i--) begin
      bit_in(s7[i], 1'b1, "novl_bit");
      chk("novl_match_exp", int'(match), int'(i == 3));
    end
    chk("novl_cnt", int'(match_cnt), 1);
    end_run();

    // Target of 2 ends the run
    step(1'b1, 4'b1011, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, "tgt_start");
    for (int i = 6; i >= 0; i--) bit_in(s7[i], 1'b1, "tgt_bit");
    chk("tgt_done", int'(done), 1);
    chk("tgt_busy", int'(busy), 0);
    for (int i = 0; i < 4; i++) begin
      bit_in(1'b1, 1'b1, "tgt_after");
      chk("tgt_after_match", int'(match), 0);
    end
    chk("tgt_done_once", int'(done), 0);
    chk("tgt_cnt_hold", int'(match_cnt), 2);

    // Valid gaps are skipped
    step(1'b1, 4'b1011, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, "gap_start");
    bit_in(1'b1, 1'b1, "gap");
    bit_in(1'b1, 1'b0, "gap");
    bit_in(1'b0, 1'b1, "gap");
    bit_in(1'b0, 1'b0, "gap");
    bit_in(1'b1, 1'b1, "gap");
    bit_in(1'b0, 1'b0, "gap");
    chk("gap_nomatch", int'(match), 0);
    bit_in(1'b1, 1'b1, "gap");
    chk("gap_match", int'(match), 1);
    chk("gap_cnt", int'(match_cnt), 1);
    bit_in(1'b1, 1'b0, "gap");
    chk("gap_hold", int'(match), 0);
    end_run();

    // Abort on the match edge wins
    step(1'b1, 4'b1011, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, "abt_start");
    bit_in(1'b1, 1'b1, "abt");
    bit_in(1'b0, 1'b1, "abt");
    bit_in(1'b1, 1'b1, "abt");
    step(1'b0, 4'b0000, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, "abt_edge");
    chk("abt_match", int'(match), 0);
    chk("abt_done", int'(done), 0);
    chk("abt_cnt", int'(match_cnt), 0);
    chk("abt_busy", int'(busy), 0);
    step(1'b1, 4'b1011, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, "abt_restart");
    chk("abt_restart_busy", int'(busy), 1);
    chk("abt_restart_cnt", int'(match_cnt), 0);

    // Asynchronous reset mid-run, while a match pulse is showing
    for (int i = 3; i >= 0; i--) bit_in(s7[i], 1'b1, "rst_bit");
    chk("rst_pre_match", int'(match), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_match", int'(match), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_cnt", int'(match_cnt), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      logic [CW-1:0] t;
      t = ($urandom_range(0, 2) == 0) ? CW'($urandom_range(1, 7)) : '0;
      step(1'($urandom_range(0, 3) == 0), PW'($urandom_range(0, 15)), 1'($urandom),
           t, 1'($urandom), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 39) == 0), "rand");
      if (c == 2000) begin
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_model("rand_rst");
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
